seg7_scan: RTL and testbench
============================

# seg7_scan

Display scan driver downstream of the bin2BCD converter in the lab3 adder datapath. It steps the converter's `sel` input through all four BCD digits and captures each returned `bcd` nibble. It then drives a 4-digit, common-anode, multiplexed seven-segment display with one digit lit at a time. An anti-ghosting blank interval separates digits, and optional leading-zero suppression is applied.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot. Legal range is `CLK_DIV >= 2`.
- `BLANK_CYC`, default 500: all-anodes-off cycles at the start of each slot. Legal range is `1 <= BLANK_CYC < CLK_DIV`.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `bcd`, in, 4: digit value returned by bin2BCD for the current `sel`; treated as combinational from `sel`.
- `blank_lead`, in, 1: 1 enables leading-zero suppression; sampled at each digit latch.
- `sel`, out, 2: digit index to bin2BCD. 00 = thousands (leftmost), 11 = units.
- `an`, out, 4: anode enables, active-low. `an[3]` is digit sel=00 and `an[0]` is digit sel=11.
- `seg`, out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `frame_done`, out, 1: one-cycle pulse when a full 4-digit scan completes.

## Operation
- Slot counter `cnt` runs 0..`CLK_DIV`-1, then wraps to 0.
  - On the wrap, `sel` increments, with 11 wrapping to 00.
  - On the 11→00 wrap, `frame_done`=1 for that single cycle.
- Each slot has two phases:
  - **BLANK**: `cnt` < `BLANK_CYC`. `an`=1111. `sel` already points at the new digit, so `bcd` settles during this phase.
  - **SHOW**: `cnt` >= `BLANK_CYC`. Exactly one anode is low, selected by `sel`.
- Digit latch: on the edge where `cnt`==`BLANK_CYC`-1, `bcd` is decoded into `seg`, and `an` drives the current digit low. `seg` then holds until the next latch.
- Decode, 0..9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Invalid `bcd` (10..15) decodes to dash 0111111.
- Leading-zero suppression:
  - Internal flag `lz` is set to 1 when the sel=00 digit is latched, before that digit is evaluated.
  - For sel 00..10: if `blank_lead`=1, `lz`=1 and `bcd`==0, then `seg`=1111111 and `an` stays 1111 for the slot.
  - Any latched digit that is nonzero or invalid clears `lz`.
  - Digit sel=11 is never suppressed, so 0 displays as "0".
- `blank_lead`=0: all four digits are always shown, including zeros.

## Timing
- Reset values: `cnt`=0, `sel`=00, `an`=1111, `seg`=1111111, `frame_done`=0, `lz`=1.
  - Reset asserted mid-slot forces all of these on the next edge.
  - The first slot after release is sel=00, beginning with BLANK.
- `an` returns to 1111 on the edge where `cnt` wraps, at the same edge `sel` advances. No cycle ever has `an` lit with a stale `sel`.
- Per slot, the digit is lit for `CLK_DIV`-`BLANK_CYC` cycles.
- A full frame is 4×`CLK_DIV` cycles.
- `bcd` changes outside the latch edge have no effect until the next slot's latch.
- All outputs are registered. `sel` is registered and feeds bin2BCD combinationally, so `bcd` has the whole BLANK phase (≥1 cycle) to settle.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles.
  - Required: `an`=1111, `seg`=1111111, `sel`=00, `frame_done`=0.
- **Scan order** (`CLK_DIV`=8, `BLANK_CYC`=2, `blank_lead`=0): model bin2BCD with sum=123.
  - `sel` sequence 00,01,10,11 advances every 8 cycles.
  - `an` is low for 6 of 8 cycles per slot: 0111, 1011, 1101, 1110.
  - `seg` sequence: 1000000, 1111001, 0100100, 0110000.
  - `frame_done` pulses once per 32 cycles.
- **Leading zeros**: sum=7 with `blank_lead`=1.
  - Digits 00..10: `an` stays 1111 and `seg`=1111111.
  - Digit 11: `seg`=1111000 on `an`=1110.
  - sum=0 shows only a units "0" (1000000).
- **Embedded zero**: sum=105 with `blank_lead`=1.
  - Thousands digit blanked.
  - Digits show 1111001, 1000000, 0010010; the tens zero is shown.
- **Invalid digit**: force `bcd`=4'hC during a latch edge.
  - Required: `seg`=0111111, and the next zero digit is not suppressed.
- **Mid-slot reset**: assert `rst_n`=0 at `sel`=10, `cnt`=5.
  - Next edge: `an`=1111, `sel`=00, `cnt`=0.
  - After release, the scan restarts at thousands with a 2-cycle blank.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit common-anode seven-segment scan driver.
// Steps bin2BCD through digits, blanks between slots, optional leading-zero suppression.
module seg7_scan #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    input  logic       blank_lead,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LATCH = CW'(BLANK_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic          lz_q, lz_d;
    logic          lz_eff;
    logic          suppress;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        sel_d        = sel_q;
        an_d         = an_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;
        lz_d         = lz_q;
        // The thousands digit restarts suppression before it is itself evaluated.
        lz_eff       = (sel_q == 2'b00) | lz_q;
        suppress     = blank_lead & lz_eff & (bcd == 4'd0) & (sel_q != 2'b11);

        if (cnt_q == CNT_LATCH) begin
            seg_d = suppress ? '1 : decode(bcd);
            an_d  = suppress ? '1 : ~(4'b1000 >> sel_q);
            lz_d  = lz_eff & (bcd == 4'd0);
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            sel_d        = sel_q + 2'd1;
            an_d         = '1;
            frame_done_d = (sel_q == 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= '0;
            an_q         <= '1;
            seg_q        <= '1;
            frame_done_q <= 1'b0;
            lz_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            lz_q         <= lz_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CLK_DIV=8, BLANK_CYC=2 and a behavioural bin2BCD.
module tb_seg7_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd;
    logic       blank_lead;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    int         sum;
    logic       inv_en;
    int         total;
    int         bad;

    seg7_scan #(
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd        (bcd),
        .blank_lead (blank_lead),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bin2BCD stand-in; inv_en injects an invalid nibble on the thousands digit.
    always_comb begin
        case (sel)
            2'd0:    bcd = 4'((sum / 1000) % 10);
            2'd1:    bcd = 4'((sum / 100) % 10);
            2'd2:    bcd = 4'((sum / 10) % 10);
            default: bcd = 4'(sum % 10);
        endcase
        if (inv_en && sel == 2'd0) bcd = 4'hC;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge where cnt=0 of slot 0; returns at the same point of the next frame.
    task automatic check_frame(input string name, input logic first,
                               input logic [15:0] an_v, input logic [27:0] seg_v);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("%s sel s%0d k%0d", name, s, k), 32'(sel), 32'(s));
                check($sformatf("%s an s%0d k%0d", name, s, k), 32'(an),
                      (k < 2) ? 32'hF : 32'(an_v[(3-s)*4 +: 4]));
                if (k >= 2)
                    check($sformatf("%s seg s%0d k%0d", name, s, k), 32'(seg),
                          32'(seg_v[(3-s)*7 +: 7]));
                check($sformatf("%s frame_done s%0d k%0d", name, s, k), 32'(frame_done),
                      (s == 0 && k == 0 && !first) ? 32'd1 : 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        sum        = 123;
        inv_en     = 1'b0;
        blank_lead = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset an", 32'(an), 32'hF);
        check("reset seg", 32'(seg), 32'h7F);
        check("reset sel", 32'(sel), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        check_frame("scan123", 1'b1, 16'b0111_1011_1101_1110,
                    {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});

        blank_lead = 1'b1;
        sum        = 7;
        check_frame("lz7", 1'b0, 16'b1111_1111_1111_1110,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});

        sum = 0;
        check_frame("lz0", 1'b0, 16'b1111_1111_1111_1110,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});

        sum = 105;
        check_frame("emb105", 1'b0, 16'b1111_1011_1101_1110,
                    {7'b1111111, 7'b1111001, 7'b1000000, 7'b0010010});

        sum    = 5;
        inv_en = 1'b1;
        check_frame("inv", 1'b0, 16'b0111_1011_1101_1110,
                    {7'b0111111, 7'b1000000, 7'b1000000, 7'b0010010});
        inv_en = 1'b0;

        blank_lead = 1'b0;
        sum        = 123;
        repeat (21) @(negedge clk);
        check("midrst pre sel", 32'(sel), 32'd2);
        check("midrst pre an", 32'(an), 32'b1101);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst an", 32'(an), 32'hF);
        check("midrst sel", 32'(sel), 32'd0);
        check("midrst seg", 32'(seg), 32'h7F);
        check("midrst frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        check_frame("restart", 1'b1, 16'b0111_1011_1101_1110,
                    {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});
        check("restart wrap frame_done", 32'(frame_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
